// File: rtl/signed_multiplier.sv
// Two-stage pipelined two's-complement multiplier (radix-4 Booth, carry-save tree, final CPA).
// Stage 1 registers the operands; stage 2 registers the reduced product.
module signed_multiplier #(
    parameter int BIT_WIDTH    = 16,
    parameter int RESULT_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [BIT_WIDTH-1:0]    multiplicand,
    input  logic [BIT_WIDTH-1:0]    multiplier,
    output logic                    out_valid,
    output logic [RESULT_WIDTH-1:0] product
);

    // Arithmetic runs modulo 2^RESULT_WIDTH, which yields both the sign-extended
    // and the wrapped result directly.
    localparam int W   = RESULT_WIDTH;
    localparam int BWE = BIT_WIDTH + (BIT_WIDTH % 2);
    localparam int ND  = BWE / 2;
    localparam int NR  = ND + 1;
    localparam int NT  = 3 * NR - 4;

    logic [BIT_WIDTH-1:0] a_r, b_r;
    logic                 v_r;

    logic [W-1:0]   a_w, a2_w;
    logic [BWE-1:0] b_e;
    logic [BWE:0]   b_x;
    logic [W-1:0]   rows [NT];
    logic [W-1:0]   corr;
    logic [W-1:0]   sum;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_r       <= '0;
            b_r       <= '0;
            v_r       <= 1'b0;
            out_valid <= 1'b0;
            product   <= '0;
        end else begin
            a_r       <= multiplicand;
            b_r       <= multiplier;
            v_r       <= in_valid;
            out_valid <= v_r;
            if (v_r) begin
                product <= sum;
            end
        end
    end

    assign a_w  = W'($signed(a_r));
    assign a2_w = a_w << 1;
    assign b_e  = BWE'($signed(b_r));
    assign b_x  = {b_e, 1'b0};

    always_comb begin
        logic [2:0]   trip;
        logic [W-1:0] sel;
        logic         neg;
        corr = '0;
        for (int i = 0; i < NT; i++) begin
            rows[i] = '0;
        end
        for (int i = 0; i < ND; i++) begin
            trip = b_x[2*i +: 3];
            sel  = '0;
            neg  = 1'b0;
            case (trip)
                3'b001, 3'b010: sel = a_w;
                3'b011:         sel = a2_w;
                3'b100: begin sel = a2_w; neg = 1'b1; end
                3'b101, 3'b110: begin sel = a_w; neg = 1'b1; end
                default: begin sel = '0; neg = 1'b0; end
            endcase
            rows[i] = (neg ? ~sel : sel) << (2 * i);
            if (2 * i < W) begin
                corr[2*i] = neg;
            end
        end
        rows[ND] = corr;
        // Rows are consumed three at a time in FIFO order, so each CSA output
        // re-enters the tree behind the unreduced rows (Wallace-style levels).
        for (int s = 0; s < NR - 2; s++) begin
            rows[NR + 2*s]     = rows[3*s] ^ rows[3*s+1] ^ rows[3*s+2];
            rows[NR + 2*s + 1] = ((rows[3*s] & rows[3*s+1]) |
                                  (rows[3*s] & rows[3*s+2]) |
                                  (rows[3*s+1] & rows[3*s+2])) << 1;
        end
    end

    assign sum = rows[NT-2] + rows[NT-1];

endmodule

// File: tb/tb_signed_multiplier.sv
// Scoreboard bench for signed_multiplier: directed sign/corner cases, streaming,
// mid-stream reset and randomized traffic checked against plain signed arithmetic.
module tb_signed_multiplier;

    typedef struct {
        logic [31:0] p;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] multiplicand;
    logic [15:0] multiplier;
    logic        out_valid;
    logic [31:0] product;

    exp_t        exp_q[$];
    int          cyc;
    int          checks;
    int          errors;
    logic [31:0] last_prod;
    logic        rst_edge;

    signed_multiplier #(.BIT_WIDTH(16), .RESULT_WIDTH(32)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .multiplicand(multiplicand),
        .multiplier(multiplier),
        .out_valid(out_valid),
        .product(product)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
        longint full;
        full = longint'($signed(a)) * longint'($signed(b));
        return full[31:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: reset bookkeeping on the rising edge, comparisons on the falling edge.
    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            exp_q.delete();
            last_prod = '0;
            rst_edge  = 1'b1;
        end else begin
            rst_edge = 1'b0;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_edge) begin
            check("reset_out_valid", {31'b0, out_valid}, 32'd0);
            check("reset_product", product, 32'd0);
        end else if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", {31'b0, out_valid}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("product", product, e.p);
                check("latency_cycle", 32'(cyc), 32'(e.cyc));
                last_prod = product;
            end
        end else begin
            check("hold_product", product, last_prod);
            if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
                check("missing_out_valid", {31'b0, out_valid}, 32'd1);
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [31:0] expv);
        exp_t e;
        in_valid     = 1'b1;
        multiplicand = a;
        multiplier   = b;
        e.p   = expv;
        e.cyc = cyc + 2;
        exp_q.push_back(e);
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid     = 1'b0;
            multiplicand = 16'($urandom);
            multiplier   = 16'($urandom);
            step();
        end
    endtask

    logic [15:0] da [11];
    logic [15:0] db [11];
    logic [31:0] dp [11];

    initial begin
        logic [15:0] ra, rb;
        checks = 0;
        errors = 0;
        cyc = 0;
        last_prod = '0;
        rst_edge = 1'b0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        multiplicand = '0;
        multiplier = '0;

        da[0]  = 16'h0100; db[0]  = 16'h0200; dp[0]  = 32'h00020000;
        da[1]  = 16'h0100; db[1]  = 16'hFE00; dp[1]  = 32'hFFFE0000;
        da[2]  = 16'hFF00; db[2]  = 16'h0200; dp[2]  = 32'hFFFE0000;
        da[3]  = 16'hFF00; db[3]  = 16'hFE00; dp[3]  = 32'h00020000;
        da[4]  = 16'd15;   db[4]  = 16'd25;   dp[4]  = 32'h00000177;
        da[5]  = 16'h0000; db[5]  = 16'h1234; dp[5]  = 32'h00000000;
        da[6]  = 16'h0001; db[6]  = 16'h0001; dp[6]  = 32'h00000001;
        da[7]  = 16'h7FFF; db[7]  = 16'h0002; dp[7]  = 32'h0000FFFE;
        da[8]  = 16'hCFC7; db[8]  = 16'h09A4; dp[8]  = 32'hFE2F1A7C;
        da[9]  = 16'h8000; db[9]  = 16'h8000; dp[9]  = 32'h40000000;
        da[10] = 16'h8000; db[10] = 16'h7FFF; dp[10] = 32'hC0008000;

        step();
        step();
        rst_n = 1'b1;
        idle(2);

        // Directed cases, each isolated by idle gaps.
        for (int i = 0; i < 11; i++) begin
            issue(da[i], db[i], dp[i]);
            idle(3);
        end

        // Identities by +1 / -1 on the other operand.
        issue(16'h8000, 16'h0001, 32'hFFFF8000);
        issue(16'h1234, 16'hFFFF, 32'hFFFFEDCC);
        idle(3);

        // Streaming: eight back-to-back pairs.
        for (int i = 0; i < 8; i++) begin
            issue(da[i], db[i], dp[i]);
        end
        idle(4);

        // Reset with two pairs in flight; neither may emerge.
        issue(16'h1111, 16'h2222, ref_mul(16'h1111, 16'h2222));
        in_valid     = 1'b1;
        multiplicand = 16'h3333;
        multiplier   = 16'h4444;
        exp_q.push_back('{p: ref_mul(16'h3333, 16'h4444), cyc: cyc + 2});
        rst_n = 1'b0;
        step();
        rst_n    = 1'b1;
        in_valid = 1'b0;
        idle(5);

        // Randomized traffic with gaps and occasional extreme operands.
        for (int i = 0; i < 10000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            case ($urandom_range(0, 9))
                0: ra = 16'h8000;
                1: rb = 16'h8000;
                2: ra = 16'h7FFF;
                3: rb = 16'hFFFF;
                default: ;
            endcase
            if ($urandom_range(0, 3) != 0) begin
                issue(ra, rb, ref_mul(ra, rb));
            end else begin
                idle(1);
            end
        end
        idle(5);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
